// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: R-type opcode/funct7 constants and the ALU op encoding
// used by both the decode stage and execute.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_XOR     = 4'b0010,
    ALU_OR      = 4'b0011,
    ALU_AND     = 4'b0100,
    ALU_SLL     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_SLT     = 4'b1000,
    ALU_SLTU    = 4'b1001,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  // Anything outside the supported R-type set maps to ALU_ILLEGAL.
  function automatic alu_op_e decode_rtype(input logic [31:0] instr);
    alu_op_e op;
    op = ALU_ILLEGAL;
    if (instr[6:0] == OP_RTYPE) begin
      if (instr[31:25] == F7_BASE) begin
        case (instr[14:12])
          3'b000:  op = ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end else if (instr[31:25] == F7_ALT) begin
        case (instr[14:12])
          3'b000:  op = ALU_SUB;
          3'b101:  op = ALU_SRA;
          default: op = ALU_ILLEGAL;
        endcase
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports with write-first bypass,
// one synchronous write port, x0 hardwired to zero.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] rs2_value,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_value = mem[rs1_addr];
    if (wb_en && wb_addr == rs1_addr) rs1_value = wb_data;
    if (rs1_addr == '0) rs1_value = '0;
  end

  always_comb begin
    rs2_value = mem[rs2_addr];
    if (wb_en && wb_addr == rs2_addr) rs2_value = wb_data;
    if (rs2_addr == '0) rs2_value = '0;
  end

endmodule

// File: rtl/rtype_decode_stage.sv
// R-type decode / operand-fetch stage: one handshaked output register feeding execute,
// with writeback bypass at fetch and refresh of a stalled bundle's operands.
module rtype_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_rs1_value,
  output logic [XLEN-1:0] out_rs2_value,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_we,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [31:0]     issue_count
);

  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rf_rs1, rf_rs2;
  alu_op_e         dec_op;
  logic            dec_illegal;
  logic            accept, issue;

  assign rd          = in_instr[11:7];
  assign rs1         = in_instr[19:15];
  assign rs2         = in_instr[24:20];
  assign dec_op      = decode_rtype(in_instr);
  assign dec_illegal = (dec_op == ALU_ILLEGAL);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid && out_ready;

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1),
    .rs2_addr  (rs2),
    .rs1_value (rf_rs1),
    .rs2_value (rf_rs2),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_alu_op    <= '0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
      out_rs1_addr  <= '0;
      out_rs2_addr  <= '0;
      out_rd_addr   <= '0;
      out_rd_we     <= 1'b0;
      out_illegal   <= 1'b0;
      issue_count   <= '0;
    end else begin
      if (issue) issue_count <= issue_count + 32'd1;
      if (accept) begin
        out_valid     <= 1'b1;
        out_alu_op    <= dec_op;
        out_illegal   <= dec_illegal;
        out_rd_addr   <= rd;
        out_rd_we     <= !dec_illegal && (rd != 5'd0);
        // Illegal bundles carry x0 sources so a later refresh cannot revive their operands.
        out_rs1_addr  <= dec_illegal ? 5'd0 : rs1;
        out_rs2_addr  <= dec_illegal ? 5'd0 : rs2;
        out_rs1_value <= dec_illegal ? '0 : rf_rs1;
        out_rs2_value <= dec_illegal ? '0 : rf_rs2;
      end else if (issue) begin
        out_valid <= 1'b0;
      end else if (out_valid) begin
        if (wb_en && wb_addr != 5'd0 && wb_addr == out_rs1_addr) out_rs1_value <= wb_data;
        if (wb_en && wb_addr != 5'd0 && wb_addr == out_rs2_addr) out_rs2_value <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_rtype_decode_stage.sv
// Self-checking bench for rtype_decode_stage: directed scenarios plus a randomized
// stream checked against a behavioural model of the stage.
module tb_rtype_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic        out_valid, out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_rs1_value, out_rs2_value;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic        out_rd_we, out_illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] issue_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtype_decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_count(issue_count)
  );

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic        m_valid, m_we, m_ill;
  logic [3:0]  m_op;
  logic [31:0] m_rs1v, m_rs2v, m_cnt;
  logic [4:0]  m_rs1a, m_rs2a, m_rda;

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [3:0] ref_op(input logic [31:0] ins);
    if (ins[6:0] != 7'b0110011) return 4'hF;
    case ({ins[31:25], ins[14:12]})
      {7'h00, 3'd0}: return 4'h0;
      {7'h00, 3'd1}: return 4'h5;
      {7'h00, 3'd2}: return 4'h8;
      {7'h00, 3'd3}: return 4'h9;
      {7'h00, 3'd4}: return 4'h2;
      {7'h00, 3'd5}: return 4'h6;
      {7'h00, 3'd6}: return 4'h3;
      {7'h00, 3'd7}: return 4'h4;
      {7'h20, 3'd0}: return 4'h1;
      {7'h20, 3'd5}: return 4'h7;
      default:       return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 0; m_we = 0; m_ill = 0; m_op = 0;
    m_rs1v = 0; m_rs2v = 0; m_cnt = 0; m_rs1a = 0; m_rs2a = 0; m_rda = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic acc, iss, ill;
    acc = in_valid && (!m_valid || out_ready);
    iss = m_valid && out_ready;
    if (iss) m_cnt = m_cnt + 1;
    if (acc) begin
      ill     = (ref_op(in_instr) == 4'hF);
      m_valid = 1;
      m_op    = ref_op(in_instr);
      m_ill   = ill;
      m_rda   = in_instr[11:7];
      m_we    = !ill && in_instr[11:7] != 0;
      m_rs1a  = ill ? 5'd0 : in_instr[19:15];
      m_rs2a  = ill ? 5'd0 : in_instr[24:20];
      m_rs1v  = ill ? 32'd0 : ref_read(in_instr[19:15]);
      m_rs2v  = ill ? 32'd0 : ref_read(in_instr[24:20]);
    end else if (iss) begin
      m_valid = 0;
    end else if (m_valid && wb_en && wb_addr != 0) begin
      if (wb_addr == m_rs1a) m_rs1v = wb_data;
      if (wb_addr == m_rs2a) m_rs2v = wb_data;
    end
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_instr = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_alu_op, out_rs1_value, out_rs2_value, out_rs1_addr, out_rs2_addr, out_rd_addr, out_rd_we, out_illegal} !== '0)
      begin errors++; $display("FAIL reset_bundle: bundle not cleared, op=%h rs1v=%h rs2v=%h", out_alu_op, out_rs1_value, out_rs2_value); end
    checks++; if (issue_count !== 32'd0) begin errors++; $display("FAIL reset_issue_count: got %h want 0", issue_count); end
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    idle_inputs();
    wb_en = 1; wb_addr = 5; wb_data = 32'h0000000A; cycle();
    wb_addr = 6; wb_data = 32'h00000003; cycle();
    wb_en = 0; in_valid = 1; in_instr = 32'h006283B3; cycle();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++; if (out_alu_op !== 4'b0000) begin errors++; $display("FAIL add_op: got %h want 0", out_alu_op); end
    checks++; if (out_rs1_value !== 32'hA) begin errors++; $display("FAIL add_rs1: got %h want 0000000a", out_rs1_value); end
    checks++; if (out_rs2_value !== 32'h3) begin errors++; $display("FAIL add_rs2: got %h want 00000003", out_rs2_value); end
    checks++; if (out_rd_addr !== 5'd7 || out_rd_we !== 1'b1) begin errors++; $display("FAIL add_rd: got rd=%0d we=%b want rd=7 we=1", out_rd_addr, out_rd_we); end
    cycle();
  endtask

  task automatic test_decode();
    idle_inputs();
    in_valid = 1; in_instr = mk_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd8); cycle();
    checks++; if (out_alu_op !== 4'b0001) begin errors++; $display("FAIL sub_op: got %h want 1", out_alu_op); end
    checks++; if (out_rs1_value !== 32'hA || out_rs2_value !== 32'h3) begin errors++; $display("FAIL sub_operands: got %h %h want a 3", out_rs1_value, out_rs2_value); end
    in_instr = mk_r(7'h20, 5'd3, 5'd2, 3'd5, 5'd1); cycle();
    checks++; if (out_alu_op !== 4'b0111 || out_illegal !== 1'b0) begin errors++; $display("FAIL sra_op: got %h ill=%b want 7 ill=0", out_alu_op, out_illegal); end
    in_instr = mk_r(7'h01, 5'd6, 5'd5, 3'd0, 5'd7); cycle();
    checks++; if (out_illegal !== 1'b1 || out_alu_op !== 4'hF || out_rd_we !== 1'b0) begin errors++; $display("FAIL mul_illegal: got ill=%b op=%h we=%b want 1 f 0", out_illegal, out_alu_op, out_rd_we); end
    checks++; if (out_rs1_value !== 32'd0 || out_rs2_value !== 32'd0) begin errors++; $display("FAIL mul_operands: got %h %h want 0 0", out_rs1_value, out_rs2_value); end
    for (int i = 0; i < 40; i++) begin
      in_instr = mk_r(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
      if (i % 8 == 7) in_instr = $urandom;
      cycle();
      checks++; if (out_alu_op !== m_op || out_illegal !== m_ill || out_rd_we !== m_we)
        begin errors++; $display("FAIL decode_rand: instr=%h got op=%h ill=%b we=%b want op=%h ill=%b we=%b", in_instr, out_alu_op, out_illegal, out_rd_we, m_op, m_ill, m_we); end
    end
    in_valid = 0; cycle();
  endtask

  task automatic test_bypass();
    idle_inputs();
    in_valid = 1; in_instr = 32'h006283B3; wb_en = 1; wb_addr = 5; wb_data = 32'h12345678; cycle();
    idle_inputs();
    checks++; if (out_rs1_value !== 32'h12345678) begin errors++; $display("FAIL bypass_rs1: got %h want 12345678", out_rs1_value); end
    checks++; if (out_rs2_value !== 32'h3) begin errors++; $display("FAIL bypass_rs2: got %h want 00000003", out_rs2_value); end
    cycle();
  endtask

  task automatic test_stall();
    logic [31:0] s_rs1v, s_cnt;
    idle_inputs();
    in_valid = 1; in_instr = 32'h006283B3; cycle();
    s_rs1v = m_rs1v;
    out_ready = 0; in_instr = mk_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd9);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd7 || out_alu_op !== 4'd0 || out_rs1_value !== s_rs1v || out_rs2_value !== 32'h3)
        begin errors++; $display("FAIL stall_hold: cycle %0d got v=%b rd=%0d op=%h rs1=%h rs2=%h", i, out_valid, out_rd_addr, out_alu_op, out_rs1_value, out_rs2_value); end
    end
    wb_en = 1; wb_addr = 6; wb_data = 32'hDEADBEEF; cycle();
    wb_en = 0;
    checks++; if (out_rs2_value !== 32'hDEADBEEF) begin errors++; $display("FAIL refresh_rs2: got %h want deadbeef", out_rs2_value); end
    checks++; if (out_rs1_value !== s_rs1v || out_rd_addr !== 5'd7 || in_ready !== 1'b0)
      begin errors++; $display("FAIL refresh_stable: got rs1=%h rd=%0d in_ready=%b want rs1=%h rd=7 in_ready=0", out_rs1_value, out_rd_addr, in_ready, s_rs1v); end
    s_cnt = m_cnt;
    in_valid = 0; out_ready = 1; cycle();
    checks++; if (issue_count !== s_cnt + 32'd1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release: got count=%h valid=%b want count=%h valid=0", issue_count, out_valid, s_cnt + 32'd1); end
  endtask

  task automatic test_x0();
    idle_inputs();
    in_valid = 1; in_instr = mk_r(7'h00, 5'd6, 5'd0, 3'd0, 5'd0);
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; cycle();
    wb_en = 0; in_instr = mk_r(7'h00, 5'd0, 5'd0, 3'd6, 5'd3);
    checks++; if (out_rs1_value !== 32'd0) begin errors++; $display("FAIL x0_bypass: got %h want 0", out_rs1_value); end
    checks++; if (out_rd_we !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL x0_rd: got we=%b ill=%b want 0 0", out_rd_we, out_illegal); end
    cycle();
    checks++; if (out_rs1_value !== 32'd0 || out_rs2_value !== 32'd0) begin errors++; $display("FAIL x0_read: got %h %h want 0 0", out_rs1_value, out_rs2_value); end
    in_valid = 0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = mk_r(($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) in_instr = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      checks++; if (in_ready !== (!m_valid || out_ready)) begin errors++; $display("FAIL rand_in_ready: step %0d got %b", i, in_ready); end
      cycle();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid: step %0d got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (out_alu_op !== m_op || out_illegal !== m_ill || out_rd_we !== m_we || out_rd_addr !== m_rda)
          begin errors++; $display("FAIL rand_decode: step %0d got op=%h ill=%b we=%b rd=%0d want %h %b %b %0d", i, out_alu_op, out_illegal, out_rd_we, out_rd_addr, m_op, m_ill, m_we, m_rda); end
        checks++; if (out_rs1_value !== m_rs1v || out_rs2_value !== m_rs2v)
          begin errors++; $display("FAIL rand_operands: step %0d got %h %h want %h %h", i, out_rs1_value, out_rs2_value, m_rs1v, m_rs2v); end
      end
      checks++; if (issue_count !== m_cnt) begin errors++; $display("FAIL rand_count: step %0d got %h want %h", i, issue_count, m_cnt); end
    end
    idle_inputs(); cycle();
  endtask

  task automatic test_back_to_back();
    test_reset();
    idle_inputs();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_instr = mk_r(7'h00, 5'd2, 5'd1, 3'(i), 5'(10 + i));
      cycle();
      checks++; if (out_valid !== 1'b1 || out_rd_addr !== 5'(10 + i))
        begin errors++; $display("FAIL b2b_bundle: slot %0d got v=%b rd=%0d want v=1 rd=%0d", i, out_valid, out_rd_addr, 10 + i); end
    end
    in_valid = 0; cycle();
    checks++; if (issue_count !== 32'd4 || out_valid !== 1'b0)
      begin errors++; $display("FAIL b2b_count: got count=%0d valid=%b want 4 0", issue_count, out_valid); end
    in_valid = 1; in_instr = 32'h006283B3; cycle();
    out_ready = 0; cycle();
    rst = 1;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || issue_count !== 32'd0)
      begin errors++; $display("FAIL midstream_reset: got valid=%b count=%0d want 0 0", out_valid, issue_count); end
    idle_inputs();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_add();
    test_decode();
    test_bypass();
    test_stall();
    test_x0();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
